// File: rtl/gray_counter_param.sv
// rtl/gray_counter_param.sv - parameterised up/down Gray counter with load and terminal-count flag
// Optional build macro: GRAY_SATURATE_EN (hold at terminal value instead of wrapping).
module gray_counter_param #(
  parameter int WIDTH = 4,
  parameter int INIT  = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin,
  output logic             tc
);

  localparam logic [WIDTH-1:0] INIT_B    = WIDTH'(INIT);
  localparam logic [WIDTH-1:0] INIT_GRAY = INIT_B ^ (INIT_B >> 1);
  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             at_term;

  // Terminal value depends on the live direction so tc tracks up_dn in the same cycle.
  always_comb begin
    at_term = up_dn ? (b_q == '1) : (b_q == '0);
    tc      = en & ~load & at_term;
  end

  always_comb begin
    b_d = b_q;
    if (load) begin
      b_d = load_val;
    end else if (en) begin
`ifdef GRAY_SATURATE_EN
      if (!at_term) begin
        b_d = up_dn ? (b_q + ONE) : (b_q - ONE);
      end
`else
      b_d = up_dn ? (b_q + ONE) : (b_q - ONE);
`endif
    end
    gray_d = b_d ^ (b_d >> 1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      b_q    <= INIT_B;
      gray_q <= INIT_GRAY;
    end else begin
      b_q    <= b_d;
      gray_q <= gray_d;
    end
  end

  assign bin  = b_q;
  assign gray = gray_q;

endmodule

// File: tb/tb_gray_counter_param.sv
// tb/tb_gray_counter_param.sv - directed and random checks for gray_counter_param
module tb_gray_counter_param;

`ifdef GRAY_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // DUT a: WIDTH=3, INIT=0
  logic       a_rst_n, a_en, a_up, a_load;
  logic [2:0] a_lv, a_gray, a_bin;
  logic       a_tc;
  gray_counter_param #(.WIDTH(3), .INIT(0)) u_a (
    .clk(clk), .rst_n(a_rst_n), .en(a_en), .up_dn(a_up), .load(a_load),
    .load_val(a_lv), .gray(a_gray), .bin(a_bin), .tc(a_tc));

  // DUT b: WIDTH=4, INIT=9
  logic       b_rst_n, b_en, b_up, b_load;
  logic [3:0] b_lv, b_gray, b_bin;
  logic       b_tc;
  gray_counter_param #(.WIDTH(4), .INIT(9)) u_b (
    .clk(clk), .rst_n(b_rst_n), .en(b_en), .up_dn(b_up), .load(b_load),
    .load_val(b_lv), .gray(b_gray), .bin(b_bin), .tc(b_tc));

  // DUT c: WIDTH=5, INIT=0, random property run
  logic       c_rst_n, c_en, c_up, c_load;
  logic [4:0] c_lv, c_gray, c_bin;
  logic       c_tc;
  gray_counter_param #(.WIDTH(5), .INIT(0)) u_c (
    .clk(clk), .rst_n(c_rst_n), .en(c_en), .up_dn(c_up), .load(c_load),
    .load_val(c_lv), .gray(c_gray), .bin(c_bin), .tc(c_tc));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] gray2bin5(input logic [4:0] g);
    logic [4:0] r;
    r[4] = g[4];
    for (int i = 3; i >= 0; i--) r[i] = r[i+1] ^ g[i];
    return r;
  endfunction

  logic [2:0] up_gray [8] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};
  logic [2:0] up_bin  [8] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
  logic       up_tc   [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    logic [4:0] m_b, prev_gray, nb;
    logic       m_term, exp_tc, en_only;

    a_rst_n = 1'b0; a_en = 1'b1; a_up = 1'b1; a_load = 1'b1; a_lv = 3'd5;
    b_rst_n = 1'b0; b_en = 1'b1; b_up = 1'b1; b_load = 1'b1; b_lv = 4'd3;
    c_rst_n = 1'b0; c_en = 1'b0; c_up = 1'b1; c_load = 1'b0; c_lv = 5'd0;
    #2;
    step();
    check("a_rst_bin", a_bin, 0);
    check("a_rst_gray", a_gray, 0);
    check("b_rst_bin", b_bin, 9);
    check("b_rst_gray", b_gray, 4'b1101);

    // Down wrap from reset state
    a_rst_n = 1'b1; a_load = 1'b0; a_en = 1'b1; a_up = 1'b0;
    b_rst_n = 1'b1; b_load = 1'b0; b_en = 1'b0;
    c_rst_n = 1'b1;
    #1;
    check("a_tc_after_rst", a_tc, 1);
    step();
    check("a_dnwrap_bin", a_bin, SAT ? 3'd0 : 3'd7);
    check("a_dnwrap_gray", a_gray, SAT ? 3'b000 : 3'b100);

    // Up-count through the wrap
    a_load = 1'b1; a_lv = 3'd0;
    #1;
    check("a_tc_load0", a_tc, 0);
    step();
    a_load = 1'b0; a_up = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      check($sformatf("a_up_tc%0d", i), a_tc, up_tc[i]);
      step();
      check($sformatf("a_up_gray%0d", i), a_gray, (SAT && i == 7) ? 3'b100 : up_gray[i]);
      check($sformatf("a_up_bin%0d", i), a_bin, (SAT && i == 7) ? 3'd7 : up_bin[i]);
    end

    // Load priority over enable, then hold
    a_load = 1'b1; a_lv = 3'd5; a_en = 1'b1;
    #1;
    check("a_tc_during_load", a_tc, 0);
    step();
    check("a_load_bin", a_bin, 5);
    check("a_load_gray", a_gray, 3'b111);
    a_load = 1'b0; a_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("a_hold_bin%0d", i), a_bin, 5);
      check($sformatf("a_hold_gray%0d", i), a_gray, 3'b111);
      check($sformatf("a_hold_tc%0d", i), a_tc, 0);
    end

    // Direction change: tc follows up_dn immediately, next edge steps new way
    a_load = 1'b1; a_lv = 3'd7;
    step();
    a_load = 1'b0; a_en = 1'b1; a_up = 1'b1;
    #1;
    check("a_tc_up_at7", a_tc, 1);
    a_up = 1'b0;
    #1;
    check("a_tc_dn_at7", a_tc, 0);
    step();
    check("a_dir_bin", a_bin, 6);
    check("a_dir_gray", a_gray, 3'b101);

    // Saturation scenario (wraps in the default build)
    a_up = 1'b1;
    step();
    check("a_sat_bin7", a_bin, 7);
    check("a_sat_gray7", a_gray, 3'b100);
    check("a_sat_tc", a_tc, 1);
    step();
    check("a_sat_hold_bin", a_bin, SAT ? 3'd7 : 3'd0);
    check("a_sat_hold_gray", a_gray, SAT ? 3'b100 : 3'b000);
    a_up = 1'b0;
    step();
    check("a_sat_dn_bin", a_bin, SAT ? 3'd6 : 3'd7);

    // Mid-count reset on WIDTH=4, INIT=9
    b_en = 1'b1; b_up = 1'b1;
    step(); step(); step();
    check("b_count12", b_bin, 12);
    b_rst_n = 1'b0; b_load = 1'b1; b_lv = 4'd3;
    step();
    check("b_midrst_bin", b_bin, 9);
    check("b_midrst_gray", b_gray, 4'b1101);
    b_rst_n = 1'b1; b_load = 1'b0;
    step();
    check("b_resume_bin", b_bin, 10);
    check("b_resume_gray", b_gray, 4'b1111);

    // Random property run on WIDTH=5 against a reference count
    m_b = 5'd0;
    for (int n = 0; n < 10000; n++) begin
      c_rst_n = ($urandom_range(199) != 0);
      c_load  = ($urandom_range(15) == 0);
      c_en    = ($urandom_range(3) != 0);
      c_up    = $urandom_range(1);
      c_lv    = 5'($urandom_range(31));
      #1;
      m_term = c_up ? (m_b == 5'd31) : (m_b == 5'd0);
      exp_tc = c_en & ~c_load & m_term;
      check("c_tc", c_tc, exp_tc);
      en_only = c_rst_n & ~c_load & c_en & ~(SAT & m_term);
      prev_gray = c_gray;
      if (!c_rst_n)     nb = 5'd0;
      else if (c_load)  nb = c_lv;
      else if (c_en && !(SAT && m_term)) nb = c_up ? m_b + 5'd1 : m_b - 5'd1;
      else              nb = m_b;
      m_b = nb;
      step();
      check("c_bin", c_bin, m_b);
      check("c_gray2bin", gray2bin5(c_gray), c_bin);
      if (en_only) check("c_hamming", $countones(c_gray ^ prev_gray), 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gray_counter_param.md
GRAY_COUNTER_PARAM -- requirements
Module: gray_counter_param

Interface
REQ-001 The module SHALL have parameter WIDTH, default 4, giving the counter width in bits; legal range 2..16.
REQ-002 The module SHALL have parameter INIT, default 0, giving the binary count value loaded at reset; legal range 0..2^WIDTH-1.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 The module SHALL have port en, input, 1 bit: count enable.
REQ-006 The module SHALL have port up_dn, input, 1 bit: direction, 1 = up, 0 = down.
REQ-007 The module SHALL have port load, input, 1 bit: synchronous load strobe.
REQ-008 The module SHALL have port load_val, input, WIDTH bits: binary value applied on load.
REQ-009 The module SHALL have port gray, output, WIDTH bits: registered Gray-coded count.
REQ-010 The module SHALL have port bin, output, WIDTH bits: registered binary count, always equal to the binary equivalent of gray.
REQ-011 The module SHALL have port tc, output, 1 bit: terminal-count flag, combinational.

Function
REQ-012 The block SHALL hold an internal binary count b; each edge SHALL set bin to the next b and gray to next_b ^ (next_b >> 1), both on the same edge, with no extra latency.
REQ-013 Edge priority SHALL be: rst_n low, then load, then en, then hold.
REQ-014 With load=1, the next b SHALL be load_val, regardless of en and up_dn.
REQ-015 With load=0, en=1 and up_dn=1, the next b SHALL be b+1 mod 2^WIDTH.
REQ-016 With load=0, en=1 and up_dn=0, the next b SHALL be b-1 mod 2^WIDTH.
REQ-017 With load=0 and en=0, b, bin and gray SHALL hold their values.
REQ-018 Every count step (not load, not reset) SHALL change exactly one bit of gray, including at the wrap in either direction.
REQ-019 tc SHALL equal en & ~load & ((up_dn & b==2^WIDTH-1) | (~up_dn & b==0)).
REQ-020 tc SHALL be 0 whenever load=1.
REQ-021 tc SHALL follow a direction change on up_dn in the same cycle.
REQ-022 A direction change while counting SHALL take effect on the next edge with no dead cycle.

Reset
REQ-023 When rst_n=0 at a rising clk edge, b and bin SHALL become INIT and gray SHALL become INIT ^ (INIT >> 1), regardless of load and en.
REQ-024 tc SHALL be computed from the reset state immediately after reset; with INIT=0, up_dn=0 and en=1, tc SHALL be 1.
REQ-025 A reset applied mid-count SHALL discard the count, and counting SHALL resume from INIT on the first edge with rst_n=1.
REQ-026 Outputs before the first reset edge SHALL be treated as unknown.

Configuration
REQ-027 Macro GRAY_SATURATE_EN SHALL select saturating mode when defined: a count step at the terminal value (all ones going up, zero going down) SHALL hold b and gray, while tc still asserts per REQ-019.
REQ-028 When GRAY_SATURATE_EN is not defined, the counter SHALL wrap per REQ-015 and REQ-016.
REQ-029 Load and reset behaviour SHALL be identical in both configurations.

Verification
REQ-030 Up-count, wrap mode: WIDTH=3, INIT=0, en=1, up_dn=1 for 9 edges -> gray sequence 000,001,011,010,110,111,101,100,000; tc=1 only while gray=100.
REQ-031 Down-count wrap: WIDTH=3, from bin=0, up_dn=0 -> gray 000 to 100 (bin 7) in one edge, with one bit changed; tc=1 before that edge.
REQ-032 Load priority: load=1, load_val=5, en=1 -> bin=5 and gray=111 next edge, tc=0 during load; then en=0 for 3 edges -> outputs hold.
REQ-033 Mid-count reset: WIDTH=4, INIT=9, count to bin=12, drive rst_n=0 for 1 edge together with load=1 -> bin=9 and gray=1101; count resumes at bin=10 and gray=1111.
REQ-034 Saturating build: GRAY_SATURATE_EN defined, WIDTH=3, up from 6 -> 7 and then holds at 7 (gray 100) with tc=1; switching up_dn=0 -> bin=6 next edge.
REQ-035 Random property check: over 10000 random cycles with WIDTH=5, every bin equals Gray-to-binary(gray), and every en-only step has Hamming distance 1.
